// File: rtl/ov7670_fb_pkg.sv
// Shared types and elaboration helpers for the ping-pong camera frame store.
package ov7670_fb_pkg;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_FILL = 2'd1,
        W_WAIT = 2'd2
    } wrState_t;

    function automatic int calcPixels(input int frameW, input int frameH);
        return frameW * frameH;
    endfunction

    function automatic bit addrFits(input int addrW, input int pixels);
        if (addrW >= 31) return 1'b1;
        return (1 << addrW) >= pixels;
    endfunction

endpackage

// File: rtl/ov7670_sdp_ram.sv
// Simple dual-port RAM: synchronous write, registered read, array not reset.
module ov7670_sdp_ram #(
    parameter int DATA_W = 1,
    parameter int DEPTH  = 2,
    parameter int ADDR_W = 1
)(
    input  logic              Clock,
    input  logic              WrEn,
    input  logic [ADDR_W-1:0] WrAddr,
    input  logic [DATA_W-1:0] WrData,
    input  logic              RdEn,
    input  logic [ADDR_W-1:0] RdAddr,
    output logic [DATA_W-1:0] RdData
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem [DEPTH];

    // Callers keep addresses below DEPTH, so only the low index bits matter.
    always_ff @(posedge Clock) begin
        if (WrEn) mem[WrAddr[IDX_W-1:0]] <= WrData;
        if (RdEn) RdData <= mem[RdAddr[IDX_W-1:0]];
    end

endmodule

// File: rtl/ov7670_frame_buffer.sv
// Double-buffered camera frame store: the writer fills one bank while the reader
// owns the other; a frame is handed over only when complete and released.
module ov7670_frame_buffer
    import ov7670_fb_pkg::*;
#(
    parameter int DATA_W  = 1,
    parameter int FRAME_W = 640,
    parameter int FRAME_H = 480,
    parameter int ADDR_W  = 19,
    parameter int CNT_W   = 8
)(
    input  logic              Clock,
    input  logic              nReset,
    input  logic              WrFrameStart,
    input  logic              WrValid,
    input  logic [DATA_W-1:0] WrData,
    input  logic              RdReq,
    input  logic [ADDR_W-1:0] RdAddr,
    input  logic              RdFrameDone,
    output logic              RdValid,
    output logic [DATA_W-1:0] RdData,
    output logic              FrameReady,
    output logic              RdBank,
    output logic              WrBusy,
    output logic [CNT_W-1:0]  DropCount
);
    localparam int                PIXELS    = calcPixels(FRAME_W, FRAME_H);
    localparam logic [ADDR_W:0]   PIX_EXT   = (ADDR_W+1)'(PIXELS);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PIXELS - 1);

    if (!addrFits(ADDR_W, PIXELS)) begin : gAddrCheck
        $error("ADDR_W is too narrow for FRAME_W*FRAME_H pixels");
    end

    wrState_t                state, nextState;
    logic [ADDR_W-1:0]       wrCnt, wrAddr;
    logic                    wrEn, restart, complete, dropInc;
    logic                    pending, swap, oor, oorQ, rdSelQ;
    logic [1:0][DATA_W-1:0]  bankQ;

    assign swap = pending && !FrameReady;
    assign oor  = {1'b0, RdAddr} >= PIX_EXT;

    always_ff @(posedge Clock) begin
        if (!nReset) state <= W_IDLE;
        else         state <= nextState;
    end

    always_comb begin
        nextState = state;
        if (swap) nextState = W_IDLE;
        else begin
            case (state)
                W_IDLE: if (WrFrameStart) nextState = W_FILL;
                W_FILL: if (complete)     nextState = W_WAIT;
                default: ;
            endcase
        end
    end

    // A restart wins over completion: the coinciding pixel becomes pixel 0.
    always_comb begin
        wrEn     = 1'b0;
        wrAddr   = wrCnt;
        restart  = 1'b0;
        complete = 1'b0;
        dropInc  = 1'b0;
        WrBusy   = (state == W_FILL);
        case (state)
            W_FILL: begin
                wrEn = WrValid;
                if (WrFrameStart) begin
                    restart = 1'b1;
                    dropInc = 1'b1;
                    wrAddr  = '0;
                end else if (WrValid && wrCnt == LAST_ADDR) begin
                    complete = 1'b1;
                end
            end
            W_WAIT:  dropInc = WrFrameStart;
            default: ;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!nReset) begin
            wrCnt      <= '0;
            pending    <= 1'b0;
            FrameReady <= 1'b0;
            RdBank     <= 1'b1;
            DropCount  <= '0;
        end else begin
            if (wrEn)                            wrCnt <= complete ? '0 : wrAddr + ADDR_W'(1);
            else if (restart || state != W_FILL) wrCnt <= '0;

            if (swap)          pending <= 1'b0;
            else if (complete) pending <= 1'b1;

            if (swap) begin
                FrameReady <= 1'b1;
                RdBank     <= ~RdBank;
            end else if (RdFrameDone && FrameReady) begin
                FrameReady <= 1'b0;
            end

            if (dropInc && DropCount != '1) DropCount <= DropCount + CNT_W'(1);
        end
    end

    // Bank select and range flag are captured with the request so a swap on
    // the same edge cannot redirect an in-flight read; oorQ=1 forces zero data.
    always_ff @(posedge Clock) begin
        if (!nReset) begin
            RdValid <= 1'b0;
            rdSelQ  <= 1'b0;
            oorQ    <= 1'b1;
        end else begin
            RdValid <= RdReq;
            if (RdReq) begin
                rdSelQ <= RdBank;
                oorQ   <= oor;
            end
        end
    end

    assign RdData = oorQ ? '0 : bankQ[rdSelQ];

    for (genvar b = 0; b < 2; b++) begin : gBank
        ov7670_sdp_ram #(
            .DATA_W (DATA_W),
            .DEPTH  (PIXELS),
            .ADDR_W (ADDR_W)
        ) uRam (
            .Clock  (Clock),
            .WrEn   (nReset && wrEn && (RdBank != 1'(b))),
            .WrAddr (wrAddr),
            .WrData (WrData),
            .RdEn   (RdReq && !oor && (RdBank == 1'(b))),
            .RdAddr (RdAddr),
            .RdData (bankQ[b])
        );
    end

endmodule
